lzc_pacogen: RTL and testbench

Parameterised leading-zero counter for the posit/PaCoGen format path. Each cycle it samples a NUM_BITS-wide word, finds the most-significant set bit and reports how many zeros precede it, plus a flag that is high when the word has at least one set bit. The result is registered, so it drops into the synchronous decode/normalise datapath with a fixed one-cycle latency.

---
 rtl/lzc_pacogen_if.sv | 40 ++++
 rtl/lzc_pacogen.sv | 101 ++++++++++
 tb/tb_lzc_pacogen.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzc_pacogen_if.sv
// -----------------------------------------------------------------------------
// lzc_pacogen_if
//
// Bundle of the data signals of the leading-zero counter. There is no
// handshake: a new word is presented every cycle, and the registered result
// for that word appears one cycle later.
//
// Parameters
//   NUM_BITS  width of the scanned word (>= 2)
//
// Signals
//   in   [NUM_BITS-1:0]        word to scan, bit NUM_BITS-1 is the MSB
//   out  [$clog2(NUM_BITS)-1:0] registered leading-zero count
//   vld                         registered "word was non-zero" flag
//
// Modports
//   master  producer of words / consumer of counts (drives in)
//   slave   the counter itself (drives out and vld)
// -----------------------------------------------------------------------------
interface lzc_pacogen_if #(
   parameter int NUM_BITS = 32
);
   localparam int OUT_W = $clog2(NUM_BITS);

   logic [NUM_BITS-1:0] in;
   logic [OUT_W-1:0]    out;
   logic                vld;

   modport master (
      output in,
      input  out,
      input  vld
   );

   modport slave (
      input  in,
      output out,
      output vld
   );
endinterface : lzc_pacogen_if

// File: rtl/lzc_pacogen.sv
// -----------------------------------------------------------------------------
// lzc_pacogen
//
// Registered leading-zero counter for the posit decode/normalise path.
// Every cycle the word on bus.in is scanned from the MSB down; the number of
// zeros in front of the highest set bit is loaded into bus.out and bus.vld is
// set when the word had any bit set. Latency is exactly one cycle, throughput
// one word per cycle, no enable and no hold.
//
// Parameters
//   NUM_BITS  word width, any value >= 2 (powers of two not required)
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, forces out=0 and vld=0
//   bus   lzc_pacogen_if.slave
//           bus.in   word to scan
//           bus.out  leading-zero count of the word sampled on the last edge
//           bus.vld  1 when that word was non-zero
//
// For an all-zero word the count is forced to 0 by construction of the tree
// (every leaf reports 0 and every merge keeps 0), so out is never X.
// -----------------------------------------------------------------------------
module lzc_pacogen #(
   parameter int NUM_BITS = 32
) (
   input  logic              clk,
   input  logic              rst,
   lzc_pacogen_if.slave      bus
);

   // Tree depth and padded width. The word is padded with zeros on the LSB
   // side up to the next power of two; zeros below the data never move the
   // position of the highest set bit, so counts on non-zero words are
   // unchanged.
   localparam int L = $clog2(NUM_BITS);
   localparam int P = 1 << L;
   localparam int LEAVES = P / 2;

   logic [P-1:0] pad;

   // Per-level node results. Level 0 holds the 2-bit leaf cells, level l
   // holds LEAVES >> l nodes whose counts are l+1 bits wide. Every entry is
   // kept at the full output width so one array serves all levels; the
   // unused high bits of the lower levels stay 0.
   logic [L-1:0] cnt_t [L][LEAVES];
   logic         vld_t [L][LEAVES];

   logic [L-1:0] cnt_q;
   logic         vld_q;

   always_comb begin
      pad = '0;
      pad[P-1 -: NUM_BITS] = bus.in;

      for (int l = 0; l < L; l++) begin
         for (int i = 0; i < LEAVES; i++) begin
            cnt_t[l][i] = '0;
            vld_t[l][i] = 1'b0;
         end
      end

      // Leaf cell on bits {2i+1, 2i}: one leading zero exactly when the
      // upper bit is clear and the lower bit is set.
      for (int i = 0; i < LEAVES; i++) begin
         vld_t[0][i]    = pad[2*i+1] | pad[2*i];
         cnt_t[0][i][0] = ~pad[2*i+1] & pad[2*i];
      end

      // Merge node: if the upper half has a set bit its count is the answer
      // with a 0 prepended; otherwise the whole upper half was zeros, so the
      // lower count gets the half-width added, which is just its valid bit
      // placed in the new MSB position l.
      for (int l = 1; l < L; l++) begin
         for (int i = 0; i < (LEAVES >> l); i++) begin
            vld_t[l][i] = vld_t[l-1][2*i+1] | vld_t[l-1][2*i];
            if (vld_t[l-1][2*i+1]) begin
               cnt_t[l][i] = cnt_t[l-1][2*i+1];
            end else begin
               cnt_t[l][i]    = cnt_t[l-1][2*i];
               cnt_t[l][i][l] = vld_t[l-1][2*i];
            end
         end
      end
   end

   // Result register, reloaded every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         vld_q <= 1'b0;
      end else begin
         cnt_q <= cnt_t[L-1][0];
         vld_q <= vld_t[L-1][0];
      end
   end

   assign bus.out = cnt_q;
   assign bus.vld = vld_q;

endmodule : lzc_pacogen

// File: tb/tb_lzc_pacogen.sv
// -----------------------------------------------------------------------------
// tb_lzc_pacogen
//
// Four counters share one clock and reset: NUM_BITS = 32, 16, 5 and 12. The
// same 32-bit word is driven to all of them, truncated to each width.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, so each sample sees the result of the word driven one cycle earlier.
// -----------------------------------------------------------------------------
module tb_lzc_pacogen;

   logic clk;
   logic rst;

   int total;
   int bad;

   lzc_pacogen_if #(.NUM_BITS(32)) if32 ();
   lzc_pacogen_if #(.NUM_BITS(16)) if16 ();
   lzc_pacogen_if #(.NUM_BITS(5))  if5 ();
   lzc_pacogen_if #(.NUM_BITS(12)) if12 ();

   lzc_pacogen #(.NUM_BITS(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
   lzc_pacogen #(.NUM_BITS(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
   lzc_pacogen #(.NUM_BITS(5))  u_dut5  (.clk(clk), .rst(rst), .bus(if5.slave));
   lzc_pacogen #(.NUM_BITS(12)) u_dut12 (.clk(clk), .rst(rst), .bus(if12.slave));

   // ---------------------------------------------------------------- clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- driver
   task automatic set_in(input logic [31:0] w);
      if32.in = w;
      if16.in = w[15:0];
      if5.in  = w[4:0];
      if12.in = w[11:0];
   endtask

   // Reference: walk from the MSB of an n-bit word down to the first 1.
   function automatic int ref_cnt(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         if (w[i]) return n - 1 - i;
      end
      return 0;
   endfunction

   function automatic logic ref_vld(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         if (w[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      set_in(32'hFFFF_FFFF);
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      // Outputs must already be cleared, before any clock edge.
      total++;
      if (if32.out !== 5'd0 || if32.vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_async32: out=%0d vld=%b want out=0 vld=0", if32.out, if32.vld);
      end
      total++;
      if (if16.out !== 4'd0 || if16.vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_async16: out=%0d vld=%b want out=0 vld=0", if16.out, if16.vld);
      end
      total++;
      if (if5.out !== 3'd0 || if5.vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_async5: out=%0d vld=%b want out=0 vld=0", if5.out, if5.vld);
      end
      total++;
      if (if12.out !== 4'd0 || if12.vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_async12: out=%0d vld=%b want out=0 vld=0", if12.out, if12.vld);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (if32.out !== 5'd0 || if32.vld !== 1'b1) begin
         bad++;
         $display("FAIL reset_release32: out=%0d vld=%b want out=0 vld=1", if32.out, if32.vld);
      end
      total++;
      if (if12.out !== 4'd0 || if12.vld !== 1'b1) begin
         bad++;
         $display("FAIL reset_release12: out=%0d vld=%b want out=0 vld=1", if12.out, if12.vld);
      end
   endtask

   task automatic test_walking_one();
      logic [31:0] w;
      for (int i = 31; i >= -1; i--) begin
         @(negedge clk);
         if (i < 31) begin
            total++;
            if (if32.out !== 5'(30 - i) || if32.vld !== 1'b1) begin
               bad++;
               $display("FAIL walk_bit%0d: out=%0d vld=%b want out=%0d vld=1",
                        i + 1, if32.out, if32.vld, 30 - i);
            end
         end
         if (i >= 0) begin
            w = 32'd1 << i;
            set_in(w);
         end
      end
   endtask

   task automatic test_dense();
      logic [31:0] vec   [3];
      logic [4:0]  e_out [3];
      logic        e_vld [3];
      vec[0] = 32'h0000_0000; e_out[0] = 5'd0;  e_vld[0] = 1'b0;
      vec[1] = 32'h0001_FFFF; e_out[1] = 5'd15; e_vld[1] = 1'b1;
      vec[2] = 32'h7FFF_FFFF; e_out[2] = 5'd1;  e_vld[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_in(vec[k]);
         @(negedge clk);
         total++;
         if (if32.out !== e_out[k] || if32.vld !== e_vld[k]) begin
            bad++;
            $display("FAIL dense_%h: out=%0d vld=%b want out=%0d vld=%b",
                     vec[k], if32.out, if32.vld, e_out[k], e_vld[k]);
         end
      end
   endtask

   task automatic test_non_pow2();
      logic [31:0] vec   [3];
      logic [3:0]  e_out [3];
      logic        e_vld [3];
      vec[0] = 32'h800; e_out[0] = 4'd0;  e_vld[0] = 1'b1;
      vec[1] = 32'h001; e_out[1] = 4'd11; e_vld[1] = 1'b1;
      vec[2] = 32'h000; e_out[2] = 4'd0;  e_vld[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_in(vec[k]);
         @(negedge clk);
         total++;
         if (if12.out !== e_out[k] || if12.vld !== e_vld[k]) begin
            bad++;
            $display("FAIL npow2_12_%h: out=%0d vld=%b want out=%0d vld=%b",
                     vec[k], if12.out, if12.vld, e_out[k], e_vld[k]);
         end
      end
      // 5-bit counter: MSB and LSB extremes.
      @(negedge clk);
      set_in(32'h10);
      @(negedge clk);
      total++;
      if (if5.out !== 3'd0 || if5.vld !== 1'b1) begin
         bad++;
         $display("FAIL npow2_5_msb: out=%0d vld=%b want out=0 vld=1", if5.out, if5.vld);
      end
      set_in(32'h01);
      @(negedge clk);
      total++;
      if (if5.out !== 3'd4 || if5.vld !== 1'b1) begin
         bad++;
         $display("FAIL npow2_5_lsb: out=%0d vld=%b want out=4 vld=1", if5.out, if5.vld);
      end
   endtask

   task automatic test_random();
      // Scoreboard entries are {vld, count}; one push per driven word.
      logic [7:0] exp32_q[$];
      logic [7:0] exp16_q[$];
      logic [7:0] exp5_q[$];
      logic [7:0] exp12_q[$];
      logic [7:0] e;
      logic [31:0] w;
      int mode;
      int nbits;
      for (int n = 0; n <= 10000; n++) begin
         @(negedge clk);
         if (exp32_q.size() > 0) begin
            e = exp32_q.pop_front();
            total++;
            if (if32.out !== e[4:0] || if32.vld !== e[7]) begin
               bad++;
               $display("FAIL rand32_%0d: out=%0d vld=%b want out=%0d vld=%b",
                        n, if32.out, if32.vld, e[4:0], e[7]);
            end
            e = exp16_q.pop_front();
            total++;
            if (if16.out !== e[3:0] || if16.vld !== e[7]) begin
               bad++;
               $display("FAIL rand16_%0d: out=%0d vld=%b want out=%0d vld=%b",
                        n, if16.out, if16.vld, e[3:0], e[7]);
            end
            e = exp5_q.pop_front();
            total++;
            if (if5.out !== e[2:0] || if5.vld !== e[7]) begin
               bad++;
               $display("FAIL rand5_%0d: out=%0d vld=%b want out=%0d vld=%b",
                        n, if5.out, if5.vld, e[2:0], e[7]);
            end
            e = exp12_q.pop_front();
            total++;
            if (if12.out !== e[3:0] || if12.vld !== e[7]) begin
               bad++;
               $display("FAIL rand12_%0d: out=%0d vld=%b want out=%0d vld=%b",
                        n, if12.out, if12.vld, e[3:0], e[7]);
            end
         end
         if (n < 10000) begin
            mode = $urandom_range(0, 7);
            if (mode == 0) begin
               w = 32'h0;
            end else if (mode <= 3) begin
               // Sparse word; bit positions biased to the narrow widths half
               // the time so the 5/12/16-bit counters see sparse words too.
               nbits = ($urandom_range(0, 1) == 0) ? 32 : 5 + 11 * $urandom_range(0, 1);
               w = 32'h0;
               for (int b = 0; b < mode; b++) begin
                  w[$urandom_range(0, nbits - 1)] = 1'b1;
               end
            end else begin
               w = $urandom;
            end
            set_in(w);
            exp32_q.push_back({ref_vld(w, 32), 2'b00, 5'(ref_cnt(w, 32))});
            exp16_q.push_back({ref_vld(w, 16), 2'b00, 5'(ref_cnt(w, 16))});
            exp5_q.push_back({ref_vld(w, 5), 2'b00, 5'(ref_cnt(w, 5))});
            exp12_q.push_back({ref_vld(w, 12), 2'b00, 5'(ref_cnt(w, 12))});
         end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      set_in(32'h00F0_0000);
      @(negedge clk);
      total++;
      if (if32.out !== 5'd8 || if32.vld !== 1'b1) begin
         bad++;
         $display("FAIL midrst_before: out=%0d vld=%b want out=8 vld=1", if32.out, if32.vld);
      end
      set_in(32'h0000_0100);
      #2 rst = 1'b1;
      #1;
      total++;
      if (if32.out !== 5'd0 || if32.vld !== 1'b0) begin
         bad++;
         $display("FAIL midrst_async: out=%0d vld=%b want out=0 vld=0", if32.out, if32.vld);
      end
      @(negedge clk);
      total++;
      if (if32.out !== 5'd0 || if32.vld !== 1'b0) begin
         bad++;
         $display("FAIL midrst_held: out=%0d vld=%b want out=0 vld=0", if32.out, if32.vld);
      end
      rst = 1'b0;
      set_in(32'h0000_0003);
      @(negedge clk);
      total++;
      if (if32.out !== 5'd30 || if32.vld !== 1'b1) begin
         bad++;
         $display("FAIL midrst_after: out=%0d vld=%b want out=30 vld=1", if32.out, if32.vld);
      end
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      set_in(32'h0);
      test_reset();
      test_walking_one();
      test_dense();
      test_non_pow2();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lzc_pacogen
